// File: rtl/seg_display_pkg.sv
// Shared types and glyph table for the 7-segment display path.
package seg_display_pkg;

    typedef logic [6:0] seg_t;

    localparam int unsigned SEG_W = 7;

    // Bit positions within seg_t, packed as {g,f,e,d,c,b,a}
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam seg_t SEG_HEX [16] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111,  // 9
        7'b1110111,  // A
        7'b1111100,  // b
        7'b0111001,  // C
        7'b1011110,  // d
        7'b1111001,  // E
        7'b1110001   // F
    };

    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high segment glyph.
module hex_to_7seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       glyph_o_c
);

    assign glyph_o_c = hex_glyph(nibble_i);

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit 7-segment scanner with blanking gap and frame-aligned double buffering.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits during their slot.
module seven_segment_scanner
    import seg_display_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic                  load,
    output logic                  load_ack,
    output logic                  frame_done,
    output logic [N_DIGITS-1:0]   an,
    output seg_t                  seg
);

    localparam int unsigned TICK_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * N_DIGITS;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

    localparam logic [0:0] SLOT_BLANK = 1'b0;
    localparam logic [0:0] SLOT_SHOW  = 1'b1;

    generate
        if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
            $error("seven_segment_scanner: N_DIGITS out of range 1..8");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("seven_segment_scanner: SCAN_DIV must be >= 2");
        end
        if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
            $error("seven_segment_scanner: BLANK_CYC must be < SCAN_DIV");
        end
    endgenerate

    logic [TICK_W-1:0]   tick_q,       tick_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [DATA_W-1:0]   active_q,     active_d;
    logic [DATA_W-1:0]   shadow_q,     shadow_d;
    logic                pending_q,    pending_d;
    logic [N_DIGITS-1:0] an_q,         an_d;
    seg_t                seg_q,        seg_d;
    logic                load_ack_q,   load_ack_d;
    logic                frame_done_q, frame_done_d;

    logic       tick_wrap_c;
    logic       boundary_c;
    logic [0:0] slot_c;
    logic [3:0] nibble_c;
    seg_t       glyph_c;
    logic       lz_blank_c;

    // Select the nibble of the digit currently owning the bus
    always_comb begin
        nibble_c = 4'h0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble_c = active_q[4*i +: 4];
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble_i  (nibble_c),
        .glyph_o_c (glyph_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are zero; digit 0 never is
    logic [N_DIGITS-1:0] lz_mask_c;

    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        lz_mask_c  = '0;
        lz_blank_c = 1'b0;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            above_zero   = above_zero & (active_q[4*i +: 4] == 4'h0);
            lz_mask_c[i] = above_zero;
        end
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                lz_blank_c = lz_mask_c[i];
            end
        end
    end
`else
    assign lz_blank_c = 1'b0;
`endif

    assign tick_wrap_c = (tick_q == TICK_LAST);
    assign boundary_c  = tick_wrap_c && (idx_q == IDX_LAST);
    assign slot_c      = (tick_q < BLANK_END) ? SLOT_BLANK : SLOT_SHOW;

    // Next-state and registered-output logic
    always_comb begin
        tick_d       = tick_q;
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        an_d         = '0;
        seg_d        = SEG_BLANK;
        load_ack_d   = 1'b0;
        frame_done_d = boundary_c;

        if (tick_wrap_c) begin
            tick_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        if (boundary_c && pending_q) begin
            active_d   = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end

        // A load on the boundary refills the shadow after the old one was applied
        if (load) begin
            shadow_d  = digits_i;
            pending_d = 1'b1;
        end

        if (slot_c == SLOT_SHOW) begin
            an_d  = N_DIGITS'(1) << idx_q;
            seg_d = lz_blank_c ? SEG_BLANK : glyph_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q       <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '0;
            seg_q        <= SEG_BLANK;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
module tb_seven_segment_scanner;

    localparam int unsigned N_DIGITS  = 4;
    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_i = 16'h0;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_i   (digits_i),
        .load       (load),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg)
    );

    // Expected glyphs per display image, packed {digit3, digit2, digit1, digit0}
    localparam logic [27:0] EXP_1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] EXP_8888 = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [27:0] EXP_C0DE = {7'h39, 7'h3F, 7'h5E, 7'h79};
    localparam logic [27:0] EXP_9ABF = {7'h6F, 7'h77, 7'h7C, 7'h71};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] EXP_ZERO = {7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [27:0] EXP_0070 = {7'h00, 7'h00, 7'h07, 7'h3F};
`else
    localparam logic [27:0] EXP_ZERO = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] EXP_0070 = {7'h3F, 7'h3F, 7'h07, 7'h3F};
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [3:0] a);
        case (a)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    logic rst_seen = 1'b0;
    always @(posedge clk) rst_seen <= rst;

    logic [27:0] cur_exp = EXP_ZERO;
    logic [3:0]  exp_an  = 4'b0001;
    logic [3:0]  cur_an  = 4'b0000;
    int          blank_run = 0;
    int          show_run  = 0;
    int          fd_cnt    = 0;

    // Monitor: checks every output cycle and retires scoreboard entries on load_ack
    always @(negedge clk) begin
        if (!rst_seen) begin
            check("reset_an", 32'(an), 32'h0);
            check("reset_seg", 32'(seg), 32'h0);
            check("reset_load_ack", 32'(load_ack), 32'h0);
            check("reset_frame_done", 32'(frame_done), 32'h0);
            cur_exp   = EXP_ZERO;
            exp_an    = 4'b0001;
            cur_an    = 4'b0000;
            blank_run = 0;
            show_run  = 0;
            fd_cnt    = 0;
        end else begin
            fd_cnt++;
            if (an == 4'b0000) begin
                check("blank_seg", 32'(seg), 32'h0);
                if (show_run != 0) begin
                    check("show_len", 32'(show_run), 32'd6);
                    show_run = 0;
                end
                blank_run++;
            end else begin
                check("an_onehot", 32'($onehot(an)), 32'h1);
                if (show_run == 0) begin
                    check("blank_len", 32'(blank_run), 32'd2);
                    check("an_seq", 32'(an), 32'(exp_an));
                    exp_an    = {exp_an[2:0], exp_an[3]};
                    cur_an    = an;
                    blank_run = 0;
                end else begin
                    check("an_stable", 32'(an), 32'(cur_an));
                end
                show_run++;
                check("seg_digit", 32'(seg), 32'(cur_exp[7*digit_of(an) +: 7]));
            end

            if (frame_done) begin
                check("frame_period", 32'(fd_cnt), 32'd32);
                fd_cnt = 0;
            end else if (fd_cnt > 32) begin
                check("frame_missing", 32'(fd_cnt), 32'd32);
                fd_cnt = 0;
            end

            if (load_ack) begin
                check("ack_with_frame", 32'(frame_done), 32'h1);
                check("ack_expected", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) cur_exp = sb.pop_front();
            end
        end
    end

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        check("frame_wait", 32'(frame_done), 32'h1);
    endtask

    task automatic load_value(input logic [15:0] v);
        digits_i = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_sb(input string name, input int n);
        #1;
        check(name, 32'(sb.size()), 32'(n));
    endtask

    initial begin
        int n;
        // Test 1: initial reset, then a mid-slot reset
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (13) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_frame(n);
        check("t1_first_frame", 32'(n), 32'd32);

        // Test 2: single load is held until the next boundary
        sb.push_back(EXP_1234);
        load_value(16'h1234);
        check_sb("t2_pending", 1);
        wait_frame(n);
        check_sb("t2_ack", 0);
        wait_frame(n);

        // Test 3: second load in the same frame overwrites the shadow
        load_value(16'h1111);
        repeat (5) @(negedge clk);
        sb.push_back(EXP_8888);
        load_value(16'h8888);
        check_sb("t3_pending", 1);
        wait_frame(n);
        check_sb("t3_ack", 0);

        // Test 4: load landing on the boundary edge
        sb.push_back(EXP_C0DE);
        load_value(16'hC0DE);
        repeat (30) @(negedge clk);
        sb.push_back(EXP_9ABF);
        load_value(16'h9ABF);
        check("t4_on_boundary", 32'(frame_done), 32'h1);
        check("t4_ack_first", 32'(load_ack), 32'h1);
        check_sb("t4_ack_a", 1);
        wait_frame(n);
        check("t4_one_frame", 32'(n), 32'd32);
        check("t4_ack_second", 32'(load_ack), 32'h1);
        check_sb("t4_ack_b", 0);

        // Test 5: free run
        repeat (100) wait_frame(n);

        // Test 6: leading zeros
        sb.push_back(EXP_0070);
        load_value(16'h0070);
        wait_frame(n);
        check_sb("t6_ack", 0);
        wait_frame(n);
        wait_frame(n);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
